// File: rtl/noc_resp_tx.sv
// Read-response transmitter: buffers headers and data words, then serialises packets onto the byte-wide NoC port.
// Optional trailing XOR checksum byte is enabled by defining NOC_RESP_CHKSUM_EN.
//
// state | meaning
// IDLE  | filler byte {1,00}; drops illegal headers, waits for a startable packet
// FRAME | READ_RESP command byte {1,40}; header popped
// RID   | ReturnID byte
// LEN   | byte-count code
// DATA  | data bytes, least-significant byte of each word first
// CHK   | XOR of the packet's data bytes (NOC_RESP_CHKSUM_EN only)
module noc_resp_tx #(
   parameter int HDR_DEPTH = 4,
   parameter int DAT_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hdr_valid,
   output logic        hdr_ready,
   input  logic [7:0]  hdr_id,
   input  logic [7:0]  hdr_len,
   input  logic        dat_valid,
   output logic        dat_ready,
   input  logic [31:0] dat_word,
   input  logic        stop,
   output logic        CmdR,
   output logic [7:0]  DataR,
   output logic        busy,
   output logic        err_len
);

   localparam int HAW = $clog2(HDR_DEPTH);
   localparam int DAW = $clog2(DAT_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FRAME = 3'd1,
      S_RID   = 3'd2,
      S_LEN   = 3'd3,
      S_DATA  = 3'd4
`ifdef NOC_RESP_CHKSUM_EN
      , S_CHK = 3'd5
`endif
   } state_t;

   logic [15:0]    hdr_mem [HDR_DEPTH];
   logic [31:0]    dat_mem [DAT_DEPTH];
   logic [HAW-1:0] hdr_wr_q, hdr_wr_d, hdr_rd_q, hdr_rd_d;
   logic [DAW-1:0] dat_wr_q, dat_wr_d, dat_rd_q, dat_rd_d;
   logic [4:0]     hdr_cnt_q, hdr_cnt_d, dat_cnt_q, dat_cnt_d;

   state_t      state_q, state_d;
   logic [1:0]  byte_q, byte_d, word_q, word_d;
   logic [7:0]  id_q, id_d, len_q, len_d;
   logic        cmd_q, cmd_d;
   logic [7:0]  data_q, data_d;
   logic        err_q, err_d;

   logic        hdr_push, hdr_pop, dat_push, dat_pop;
   logic [7:0]  head_id, head_len;
   logic [1:0]  head_nw;
   logic        head_legal, start, drop;
   logic [31:0] nxt_word;

   // Ready is forced low while reset is asserted and ignores same-cycle pops.
   assign hdr_ready = rst && (hdr_cnt_q != 5'(HDR_DEPTH));
   assign dat_ready = rst && (dat_cnt_q != 5'(DAT_DEPTH));
   assign hdr_push  = hdr_valid && hdr_ready;
   assign dat_push  = dat_valid && dat_ready;

   assign head_id    = hdr_mem[hdr_rd_q][15:8];
   assign head_len   = hdr_mem[hdr_rd_q][7:0];
   assign head_nw    = head_len[3:2];
   assign head_legal = (head_len == 8'h04) || (head_len == 8'h08) || (head_len == 8'h0C);
   assign drop  = (state_q == S_IDLE) && (hdr_cnt_q != 5'd0) && !head_legal;
   assign start = (state_q == S_IDLE) && (hdr_cnt_q != 5'd0) && head_legal &&
                  (dat_cnt_q >= {3'b000, head_nw}) && !stop;

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      word_d  = word_q;
      id_d    = id_q;
      len_d   = len_q;
      hdr_pop = 1'b0;
      dat_pop = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (drop) begin
               hdr_pop = 1'b1;
               err_d   = 1'b1;
            end else if (start) begin
               state_d = S_FRAME;
               id_d    = head_id;
               len_d   = head_len;
            end
         end
         S_FRAME: begin
            hdr_pop = 1'b1;
            state_d = S_RID;
         end
         S_RID:   state_d = S_LEN;
         S_LEN: begin
            state_d = S_DATA;
            byte_d  = 2'd0;
            word_d  = 2'd0;
         end
         S_DATA: begin
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
               dat_pop = 1'b1;
               if (word_q == len_q[3:2] - 2'd1) begin
`ifdef NOC_RESP_CHKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  word_d = word_q + 2'd1;
               end
            end
         end
`ifdef NOC_RESP_CHKSUM_EN
         S_CHK:   state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hdr_wr_d = hdr_wr_q;
      hdr_rd_d = hdr_rd_q;
      dat_wr_d = dat_wr_q;
      dat_rd_d = dat_rd_q;
      if (hdr_push) hdr_wr_d = (hdr_wr_q == HAW'(HDR_DEPTH - 1)) ? '0 : hdr_wr_q + 1'b1;
      if (hdr_pop)  hdr_rd_d = (hdr_rd_q == HAW'(HDR_DEPTH - 1)) ? '0 : hdr_rd_q + 1'b1;
      if (dat_push) dat_wr_d = (dat_wr_q == DAW'(DAT_DEPTH - 1)) ? '0 : dat_wr_q + 1'b1;
      if (dat_pop)  dat_rd_d = (dat_rd_q == DAW'(DAT_DEPTH - 1)) ? '0 : dat_rd_q + 1'b1;
      case ({hdr_push, hdr_pop})
         2'b10:   hdr_cnt_d = hdr_cnt_q + 5'd1;
         2'b01:   hdr_cnt_d = hdr_cnt_q - 5'd1;
         default: hdr_cnt_d = hdr_cnt_q;
      endcase
      case ({dat_push, dat_pop})
         2'b10:   dat_cnt_d = dat_cnt_q + 5'd1;
         2'b01:   dat_cnt_d = dat_cnt_q - 5'd1;
         default: dat_cnt_d = dat_cnt_q;
      endcase
   end

`ifdef NOC_RESP_CHKSUM_EN
   logic [7:0] chk_q, chk_d;
`endif

   // Output bytes are computed from the next state so they register in step with it;
   // the data word is read at the post-pop pointer so a new word is ready right after byte 3.
   assign nxt_word = dat_mem[dat_rd_d];

   always_comb begin
      cmd_d  = 1'b1;
      data_d = 8'h00;
      case (state_d)
         S_FRAME: data_d = 8'h40;
         S_RID: begin
            cmd_d  = 1'b0;
            data_d = id_q;
         end
         S_LEN: begin
            cmd_d  = 1'b0;
            data_d = len_q;
         end
         S_DATA: begin
            cmd_d  = 1'b0;
            data_d = nxt_word[{byte_d, 3'b000} +: 8];
         end
`ifdef NOC_RESP_CHKSUM_EN
         S_CHK: begin
            cmd_d  = 1'b0;
            data_d = chk_q;
         end
`endif
         default: begin
            cmd_d  = 1'b1;
            data_d = 8'h00;
         end
      endcase
   end

`ifdef NOC_RESP_CHKSUM_EN
   always_comb begin
      chk_d = chk_q;
      if (state_d == S_FRAME)     chk_d = 8'h00;
      else if (state_d == S_DATA) chk_d = chk_q ^ data_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) chk_q <= 8'h00;
      else      chk_q <= chk_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (hdr_push) hdr_mem[hdr_wr_q] <= {hdr_id, hdr_len};
      if (dat_push) dat_mem[dat_wr_q] <= dat_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_wr_q  <= '0;
         hdr_rd_q  <= '0;
         hdr_cnt_q <= 5'd0;
         dat_wr_q  <= '0;
         dat_rd_q  <= '0;
         dat_cnt_q <= 5'd0;
         state_q   <= S_IDLE;
         byte_q    <= 2'd0;
         word_q    <= 2'd0;
         id_q      <= 8'h00;
         len_q     <= 8'h00;
         cmd_q     <= 1'b1;
         data_q    <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         hdr_wr_q  <= hdr_wr_d;
         hdr_rd_q  <= hdr_rd_d;
         hdr_cnt_q <= hdr_cnt_d;
         dat_wr_q  <= dat_wr_d;
         dat_rd_q  <= dat_rd_d;
         dat_cnt_q <= dat_cnt_d;
         state_q   <= state_d;
         byte_q    <= byte_d;
         word_q    <= word_d;
         id_q      <= id_d;
         len_q     <= len_d;
         cmd_q     <= cmd_d;
         data_q    <= data_d;
         err_q     <= err_d;
      end
   end

   assign CmdR    = cmd_q;
   assign DataR   = data_q;
   assign busy    = (state_q != S_IDLE);
   assign err_len = err_q;

endmodule

// File: tb/tb_noc_resp_tx.sv
// Directed bench for noc_resp_tx (default build): vector table plus hand-written multi-cycle sequences.
module tb_noc_resp_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hdr_valid = 1'b0;
   logic        hdr_ready;
   logic [7:0]  hdr_id = 8'h00;
   logic [7:0]  hdr_len = 8'h00;
   logic        dat_valid = 1'b0;
   logic        dat_ready;
   logic [31:0] dat_word = 32'h0;
   logic        stop = 1'b0;
   logic        CmdR;
   logic [7:0]  DataR;
   logic        busy;
   logic        err_len;

   int n_cmp = 0;
   int n_err = 0;

   noc_resp_tx dut (
      .clk(clk), .rst(rst),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_id(hdr_id), .hdr_len(hdr_len),
      .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_word(dat_word),
      .stop(stop), .CmdR(CmdR), .DataR(DataR), .busy(busy), .err_len(err_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hv;
      logic [7:0]  hid;
      logic [7:0]  hlen;
      logic        dv;
      logic [31:0] dw;
      logic        st;
      logic        ecmd;
      logic [7:0]  edat;
      logic        ebusy;
      logic        eerr;
   } vec_t;

   vec_t tbl[$];
   logic [7:0] got_ids[$];
   int frame_cyc[$];

   function automatic vec_t mk(logic hv, logic [7:0] hid, logic [7:0] hlen, logic dv, logic [31:0] dw,
                               logic st, logic ec, logic [7:0] ed, logic eb, logic ee);
      vec_t v;
      v.hv = hv; v.hid = hid; v.hlen = hlen; v.dv = dv; v.dw = dw; v.st = st;
      v.ecmd = ec; v.edat = ed; v.ebusy = eb; v.eerr = ee;
      return v;
   endfunction

   function automatic vec_t o(logic st, logic ec, logic [7:0] ed, logic eb, logic ee);
      return mk(1'b0, 8'h00, 8'h00, 1'b0, 32'h0, st, ec, ed, eb, ee);
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      hdr_valid = 1'b0;
      dat_valid = 1'b0;
      stop      = 1'b0;
   endtask

   task automatic drain(input int n);
      bit prev_frame = 1'b0;
      got_ids.delete();
      frame_cyc.delete();
      for (int c = 0; c < 200 && got_ids.size() < n; c++) begin
         step();
         if (prev_frame) got_ids.push_back(DataR);
         prev_frame = (CmdR === 1'b1) && (DataR === 8'h40);
         if (prev_frame) frame_cyc.push_back(c);
      end
      repeat (10) step();
   endtask

   task automatic check_ids(input string name, input logic [7:0] base);
      chk({name, "_count"}, 16'(got_ids.size()), 16'd4);
      for (int k = 0; k < got_ids.size(); k++)
         chk({name, "_id"}, 16'(got_ids[k]), 16'(8'(base + 8'(k))));
      for (int k = 1; k < frame_cyc.size(); k++)
         chk({name, "_gap"}, 16'(frame_cyc[k] - frame_cyc[k-1]), 16'd8);
      chk({name, "_busy_end"}, 16'(busy), 16'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [8:0] exp77 [8];
      bit found;

      // single read response
      tbl.push_back(mk(1'b1, 8'h05, 8'h04, 1'b1, 32'hDDCCBBAA, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0));
      tbl.push_back(o(1'b0, 1'b1, 8'h40, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h05, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h04, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'hAA, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'hBB, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'hCC, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'hDD, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b1, 8'h00, 1'b0, 1'b0));
      // illegal length dropped, the pre-pushed word survives for the next header
      tbl.push_back(mk(1'b1, 8'h07, 8'h10, 1'b1, 32'h44332211, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0));
      tbl.push_back(o(1'b0, 1'b1, 8'h00, 1'b0, 1'b1));
      tbl.push_back(o(1'b0, 1'b1, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 8'h0A, 8'h04, 1'b0, 32'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0));
      tbl.push_back(o(1'b0, 1'b1, 8'h40, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h0A, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h04, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h11, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h22, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h33, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h44, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b1, 8'h00, 1'b0, 1'b0));
      // two queued packets, stop raised mid-first-packet holds the second
      tbl.push_back(mk(1'b1, 8'h11, 8'h04, 1'b1, 32'h13121110, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 8'h22, 8'h04, 1'b1, 32'h23222120, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0));
      tbl.push_back(o(1'b1, 1'b0, 8'h11, 1'b1, 1'b0));
      tbl.push_back(o(1'b1, 1'b0, 8'h04, 1'b1, 1'b0));
      tbl.push_back(o(1'b1, 1'b0, 8'h10, 1'b1, 1'b0));
      tbl.push_back(o(1'b1, 1'b0, 8'h11, 1'b1, 1'b0));
      tbl.push_back(o(1'b1, 1'b0, 8'h12, 1'b1, 1'b0));
      tbl.push_back(o(1'b1, 1'b0, 8'h13, 1'b1, 1'b0));
      tbl.push_back(o(1'b1, 1'b1, 8'h00, 1'b0, 1'b0));
      tbl.push_back(o(1'b1, 1'b1, 8'h00, 1'b0, 1'b0));
      tbl.push_back(o(1'b0, 1'b1, 8'h40, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h22, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h04, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h20, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h21, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h22, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b0, 8'h23, 1'b1, 1'b0));
      tbl.push_back(o(1'b0, 1'b1, 8'h00, 1'b0, 1'b0));

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset_out", 16'({CmdR, DataR, busy, err_len, hdr_ready, dat_ready}), 16'({1'b1, 8'h00, 4'b0000}));
      rst = 1'b1;
      #1;
      chk("reset_release_ready", 16'({hdr_ready, dat_ready}), 16'(2'b11));

      foreach (tbl[i]) begin
         hdr_valid = tbl[i].hv; hdr_id = tbl[i].hid; hdr_len = tbl[i].hlen;
         dat_valid = tbl[i].dv; dat_word = tbl[i].dw; stop = tbl[i].st;
         step();
         chk($sformatf("vec%0d", i), 16'({CmdR, DataR, busy, err_len}),
             16'({tbl[i].ecmd, tbl[i].edat, tbl[i].ebusy, tbl[i].eerr}));
      end
      idle_inputs();

      // 3-word header waits for its 3rd word, then a 15-byte packet without gaps
      hdr_valid = 1'b1; hdr_id = 8'h09; hdr_len = 8'h0C; dat_valid = 1'b1; dat_word = 32'h03020100;
      step();
      chk("short_wait0", 16'({CmdR, DataR, busy}), 16'({1'b1, 8'h00, 1'b0}));
      hdr_valid = 1'b0; dat_word = 32'h07060504;
      step();
      chk("short_wait1", 16'({CmdR, DataR, busy}), 16'({1'b1, 8'h00, 1'b0}));
      dat_valid = 1'b0;
      repeat (3) begin
         step();
         chk("short_hold", 16'({CmdR, DataR, busy}), 16'({1'b1, 8'h00, 1'b0}));
      end
      dat_valid = 1'b1; dat_word = 32'h0B0A0908;
      step();
      chk("third_push", 16'({CmdR, DataR}), 16'({1'b1, 8'h00}));
      dat_valid = 1'b0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (k == 0)      chk("pkt15", 16'({CmdR, DataR}), 16'({1'b1, 8'h40}));
         else if (k == 1) chk("pkt15", 16'({CmdR, DataR}), 16'({1'b0, 8'h09}));
         else if (k == 2) chk("pkt15", 16'({CmdR, DataR}), 16'({1'b0, 8'h0C}));
         else             chk("pkt15", 16'({CmdR, DataR}), 16'({1'b0, 8'(k - 3)}));
      end
      step();
      chk("pkt15_end", 16'({CmdR, DataR, busy}), 16'({1'b1, 8'h00, 1'b0}));

      // fill header FIFO past its depth, then drain and refill across the pointer wrap
      for (int i = 0; i < 5; i++) begin
         chk("hdr_ready_fill", 16'(hdr_ready), 16'(i < 4));
         hdr_valid = 1'b1; hdr_id = 8'(8'h30 + 8'(i)); hdr_len = 8'h04;
         step();
      end
      hdr_valid = 1'b0;
      chk("hdr_ready_full", 16'(hdr_ready), 16'd0);
      stop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dat_valid = 1'b1; dat_word = 32'hA0A1A200 + 32'(i);
         step();
      end
      dat_valid = 1'b0;
      chk("stop_holds", 16'(busy), 16'd0);
      stop = 1'b0;
      drain(4);
      check_ids("drain1", 8'h30);
      stop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         hdr_valid = 1'b1; hdr_id = 8'(8'h50 + 8'(i)); hdr_len = 8'h04;
         dat_valid = 1'b1; dat_word = 32'hB0B1B200 + 32'(i);
         step();
      end
      idle_inputs();
      drain(4);
      check_ids("drain2", 8'h50);

      // reset during the 2nd data byte
      hdr_valid = 1'b1; hdr_id = 8'h66; hdr_len = 8'h08; dat_valid = 1'b1; dat_word = 32'hC3C2C1C0;
      step();
      hdr_valid = 1'b0; dat_word = 32'hC7C6C5C4;
      step();
      dat_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (CmdR === 1'b1 && DataR === 8'h40) found = 1'b1;
         else step();
      end
      chk("rst_pkt_started", 16'(found), 16'd1);
      repeat (3) step();
      chk("rst_d0", 16'({CmdR, DataR}), 16'({1'b0, 8'hC0}));
      step();
      chk("rst_d1", 16'({CmdR, DataR}), 16'({1'b0, 8'hC1}));
      rst = 1'b0;
      #1;
      chk("rst_async", 16'({CmdR, DataR, busy, err_len, hdr_ready, dat_ready}), 16'({1'b1, 8'h00, 4'b0000}));
      step();
      step();
      chk("rst_hold", 16'({CmdR, DataR, busy, err_len, hdr_ready, dat_ready}), 16'({1'b1, 8'h00, 4'b0000}));
      rst = 1'b1;
      #1;
      chk("rst_release_ready", 16'({hdr_ready, dat_ready}), 16'(2'b11));
      repeat (6) begin
         step();
         chk("post_rst_idle", 16'({CmdR, DataR, busy}), 16'({1'b1, 8'h00, 1'b0}));
      end
      hdr_valid = 1'b1; hdr_id = 8'h77; hdr_len = 8'h04;
      step();
      hdr_valid = 1'b0;
      repeat (5) begin
         step();
         chk("dat_flushed", 16'({CmdR, DataR, busy}), 16'({1'b1, 8'h00, 1'b0}));
      end
      dat_valid = 1'b1; dat_word = 32'hE3E2E1E0;
      step();
      dat_valid = 1'b0;
      chk("post_rst_push", 16'({CmdR, DataR}), 16'({1'b1, 8'h00}));
      exp77 = '{9'h140, 9'h077, 9'h004, 9'h0E0, 9'h0E1, 9'h0E2, 9'h0E3, 9'h100};
      for (int k = 0; k < 8; k++) begin
         step();
         chk("post_rst_pkt", 16'({CmdR, DataR}), 16'(exp77[k]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
